// File: rtl/sound_clip_player.sv
// Clip sequencer: walks one of four ROM clips at a fixed sample rate and hands
// each captured sample to the audio write interface under its ready handshake.
module sound_clip_player #(
    parameter int ADDR_W       = 18,
    parameter int SAMPLE_W     = 6,
    parameter int SAMPLE_DIV   = 1200,
    parameter int WIN_START    = 0,
    parameter int WIN_END      = 16395,
    parameter int MOO_START    = 16396,
    parameter int MOO_END      = 66982,
    parameter int DETECT_START = 66983,
    parameter int DETECT_END   = 83254,
    parameter int CHEER_START  = 83255,
    parameter int CHEER_END    = 137138
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic                play,
    input  logic [1:0]          clip_sel,
    input  logic                loop,
    input  logic                stop,
    output logic [ADDR_W-1:0]   rom_address,
    input  logic [SAMPLE_W-1:0] rom_q,
    input  logic                audio_out_allowed,
    output logic                write_audio_out,
    output logic [31:0]         left_channel_audio_out,
    output logic [31:0]         right_channel_audio_out,
    output logic                busy,
    output logic                done
);

    localparam int DIV_W = $clog2(SAMPLE_DIV);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

    typedef enum logic {IDLE, PLAY} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   start_q, start_d;
    logic [ADDR_W-1:0]   end_q, end_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [SAMPLE_W-1:0] sample_q, sample_d;
    logic                pending_q, pending_d;
    logic                done_q, done_d;
    logic [ADDR_W-1:0]   sel_start, sel_end;

    always_comb begin
        sel_start = ADDR_W'(WIN_START);
        sel_end   = ADDR_W'(WIN_END);
        case (clip_sel)
            2'd1: begin
                sel_start = ADDR_W'(MOO_START);
                sel_end   = ADDR_W'(MOO_END);
            end
            2'd2: begin
                sel_start = ADDR_W'(DETECT_START);
                sel_end   = ADDR_W'(DETECT_END);
            end
            2'd3: begin
                sel_start = ADDR_W'(CHEER_START);
                sel_end   = ADDR_W'(CHEER_END);
            end
            default: ;
        endcase
    end

    assign write_audio_out = pending_q & audio_out_allowed;

    always_comb begin
        state_d   = state_q;
        start_d   = start_q;
        end_d     = end_q;
        addr_d    = addr_q;
        div_d     = div_q;
        sample_d  = sample_q;
        pending_d = pending_q;
        done_d    = 1'b0;

        // A strobe consumes the pending sample; a fresh capture below takes priority.
        if (write_audio_out)
            pending_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (play && !stop) begin
                    state_d = PLAY;
                    start_d = sel_start;
                    end_d   = sel_end;
                    addr_d  = sel_start;
                    div_d   = '0;
                end
            end
            PLAY: begin
                if (stop) begin
                    state_d   = IDLE;
                    pending_d = 1'b0;
                end else if (play) begin
                    start_d   = sel_start;
                    end_d     = sel_end;
                    addr_d    = sel_start;
                    div_d     = '0;
                    pending_d = 1'b0;
                end else begin
                    div_d = div_q + 1'b1;
                    // ROM registered the address at the end of div 0, so q is valid now.
                    if (div_q == DIV_ONE) begin
                        sample_d  = rom_q;
                        pending_d = 1'b1;
                    end
                    if (div_q == DIV_LAST) begin
                        if (addr_q < end_q) begin
                            addr_d = addr_q + 1'b1;
                            div_d  = '0;
                        end else if (loop) begin
                            addr_d = start_q;
                            div_d  = '0;
                        end else begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q   <= IDLE;
            start_q   <= '0;
            end_q     <= '0;
            addr_q    <= '0;
            div_q     <= '0;
            sample_q  <= '0;
            pending_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            start_q   <= start_d;
            end_q     <= end_d;
            addr_q    <= addr_d;
            div_q     <= div_d;
            sample_q  <= sample_d;
            pending_q <= pending_d;
            done_q    <= done_d;
        end
    end

    assign rom_address             = addr_q;
    assign busy                    = (state_q == PLAY);
    assign done                    = done_q;
    assign left_channel_audio_out  = {sample_q, {(32 - SAMPLE_W){1'b0}}};
    assign right_channel_audio_out = left_channel_audio_out;

endmodule

// File: tb/tb_sound_clip_player.sv
// Directed bench for sound_clip_player with shortened clips and a 4-cycle sample period.
module tb_sound_clip_player;

    logic        CLOCK_50 = 1'b0;
    logic        reset = 1'b1;
    logic        play = 1'b0;
    logic [1:0]  clip_sel = 2'd0;
    logic        loop = 1'b0;
    logic        stop = 1'b0;
    logic [17:0] rom_address;
    logic [5:0]  rom_q;
    logic        audio_out_allowed = 1'b0;
    logic        write_audio_out;
    logic [31:0] left_channel_audio_out;
    logic [31:0] right_channel_audio_out;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    int wcount = 0;
    int dcount = 0;
    logic [31:0] wdata[$];

    sound_clip_player #(
        .SAMPLE_DIV (4),
        .WIN_END    (3),
        .DETECT_END (66984)
    ) dut (
        .CLOCK_50                (CLOCK_50),
        .reset                   (reset),
        .play                    (play),
        .clip_sel                (clip_sel),
        .loop                    (loop),
        .stop                    (stop),
        .rom_address             (rom_address),
        .rom_q                   (rom_q),
        .audio_out_allowed       (audio_out_allowed),
        .write_audio_out         (write_audio_out),
        .left_channel_audio_out  (left_channel_audio_out),
        .right_channel_audio_out (right_channel_audio_out),
        .busy                    (busy),
        .done                    (done)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    function automatic logic [5:0] rom_f(input logic [17:0] a);
        return a[5:0] + 6'd5;
    endfunction

    function automatic logic [31:0] word(input logic [17:0] a);
        return {rom_f(a), 26'b0};
    endfunction

    // One-cycle-latency ROM model
    always @(posedge CLOCK_50) rom_q <= rom_f(rom_address);

    always @(posedge CLOCK_50) begin
        if (write_audio_out) begin
            wcount <= wcount + 1;
            wdata.push_back(left_channel_audio_out);
        end
        if (done) dcount <= dcount + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // reset state
        tick(2);
        chk("rst_busy", busy, 0);
        chk("rst_rom", rom_address, 0);
        chk("rst_write", write_audio_out, 0);
        chk("rst_left", left_channel_audio_out, 0);
        chk("rst_done", done, 0);
        reset = 1'b0;

        // reset mid-clip with a pending sample
        audio_out_allowed = 1'b0; clip_sel = 2'd1; play = 1'b1;
        tick(1); play = 1'b0;
        tick(3);
        chk("mid_left", left_channel_audio_out, word(18'd16396));
        chk("mid_rom", rom_address, 16396);
        reset = 1'b1; audio_out_allowed = 1'b1;
        tick(1);
        chk("mrst_busy", busy, 0);
        chk("mrst_rom", rom_address, 0);
        chk("mrst_write", write_audio_out, 0);
        chk("mrst_left", left_channel_audio_out, 0);
        reset = 1'b0;
        tick(1);

        // basic clip 0
        wcount = 0; wdata.delete();
        clip_sel = 2'd0; play = 1'b1;
        tick(1); play = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("basic_rom", rom_address, 18'(i / 4));
            chk("basic_busy", busy, 1);
            if (i < 2) chk("basic_early_wr", write_audio_out, 0);
            if (i == 2) begin
                chk("basic_first_wr", write_audio_out, 1);
                chk("basic_first_dat", left_channel_audio_out, word(18'd0));
                chk("basic_right", right_channel_audio_out, word(18'd0));
            end
            tick(1);
        end
        chk("basic_done", done, 1);
        chk("basic_idle", busy, 0);
        chk("basic_wcount", wcount, 4);
        for (int k = 0; k < 4; k++)
            chk("basic_wdata", (wdata.size() > k) ? wdata[k] : 32'hdead, word(18'(k)));
        tick(1);
        chk("basic_done_pulse", done, 0);

        // clip 2 looping
        dcount = 0;
        clip_sel = 2'd2; loop = 1'b1; play = 1'b1;
        tick(1); play = 1'b0;
        for (int i = 0; i < 24; i++) begin
            chk("loop_rom", rom_address, 18'(66983 + (i / 4) % 2));
            tick(1);
        end
        chk("loop_nodone", dcount, 0);
        loop = 1'b0;
        tick(7);
        chk("loop_last_rom", rom_address, 66984);
        chk("loop_last_busy", busy, 1);
        chk("loop_last_done", done, 0);
        tick(1);
        chk("loop_end_done", done, 1);
        chk("loop_end_busy", busy, 0);
        tick(1);

        // backpressure: first sample overwritten before it can drain
        audio_out_allowed = 1'b0; wcount = 0; wdata.delete();
        clip_sel = 2'd0; play = 1'b1;
        tick(1); play = 1'b0;
        tick(2);
        chk("bp_hold_wr", write_audio_out, 0);
        chk("bp_first_cap", left_channel_audio_out, word(18'd0));
        tick(6);
        chk("bp_none_yet", wcount, 0);
        chk("bp_second_cap", left_channel_audio_out, word(18'd1));
        audio_out_allowed = 1'b1;
        #1;
        chk("bp_release_wr", write_audio_out, 1);
        tick(1);
        chk("bp_single_wr", write_audio_out, 0);
        chk("bp_wcount1", wcount, 1);
        chk("bp_wdata", (wdata.size() > 0) ? wdata[0] : 32'hdead, word(18'd1));
        tick(7);
        chk("bp_done", done, 1);
        chk("bp_wcount3", wcount, 3);
        tick(1);

        // stop with a pending sample
        audio_out_allowed = 1'b0;
        clip_sel = 2'd0; play = 1'b1;
        tick(1); play = 1'b0;
        tick(2);
        stop = 1'b1;
        tick(1);
        chk("stop_busy", busy, 0);
        chk("stop_done", done, 0);
        stop = 1'b0; audio_out_allowed = 1'b1; wcount = 0; dcount = 0;
        #1;
        chk("stop_nowr", write_audio_out, 0);
        tick(8);
        chk("stop_wcount", wcount, 0);
        chk("stop_dcount", dcount, 0);
        chk("stop_idle", busy, 0);

        // retrigger mid clip 1 into clip 3
        clip_sel = 2'd1; play = 1'b1;
        tick(1); play = 1'b0;
        tick(5);
        chk("rt_rom_moo", rom_address, 16397);
        clip_sel = 2'd3; play = 1'b1;
        tick(1); play = 1'b0;
        chk("rt_rom_cheer", rom_address, 83255);
        chk("rt_busy", busy, 1);
        chk("rt_cleared", write_audio_out, 0);
        tick(1);
        chk("rt_wr_t7", write_audio_out, 0);
        tick(1);
        chk("rt_wr_t8", write_audio_out, 1);
        chk("rt_wr_dat", left_channel_audio_out, word(18'd83255));
        play = 1'b1; stop = 1'b1;
        tick(1);
        chk("ps_busy", busy, 0);
        chk("ps_done", done, 0);
        tick(1);
        chk("ps_idle_busy", busy, 0);
        play = 1'b0; stop = 1'b0;
        tick(1);

        // drain of final sample after clip end
        audio_out_allowed = 1'b0;
        clip_sel = 2'd0; play = 1'b1;
        tick(1); play = 1'b0;
        tick(16);
        chk("dr_done", done, 1);
        chk("dr_busy", busy, 0);
        chk("dr_nowr", write_audio_out, 0);
        tick(1);
        chk("dr_rom_hold", rom_address, 3);
        wcount = 0; wdata.delete();
        audio_out_allowed = 1'b1;
        #1;
        chk("dr_wr", write_audio_out, 1);
        chk("dr_dat", left_channel_audio_out, word(18'd3));
        chk("dr_wr_busy", busy, 0);
        tick(1);
        chk("dr_wr_once", write_audio_out, 0);
        chk("dr_wcount", wcount, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sound_clip_player.md
# sound_clip_player

Clip sequencer upstream of the audio output path. On a play request it selects one of four clips packed in the shared 6-bit sample ROM and walks its address range at a fixed sample rate. It captures each ROM sample and hands it to the Audio_Controller write interface under the `audio_out_allowed` handshake. It replaces free-running address counters with a clip-selectable, stoppable, loop-capable player that signals completion.

## Interface
Parameters:
- `ADDR_W`, 18, ROM address width
- `SAMPLE_W`, 6, ROM sample width
- `SAMPLE_DIV`, 1200, clock cycles per sample; must be ≥ 4
- `WIN_START` / `WIN_END`, 0 / 16395, clip 0 bounds, inclusive
- `MOO_START` / `MOO_END`, 16396 / 66982, clip 1 bounds
- `DETECT_START` / `DETECT_END`, 66983 / 83254, clip 2 bounds
- `CHEER_START` / `CHEER_END`, 83255 / 137138, clip 3 bounds

Ports:
- `CLOCK_50` in 1: sole clock, all logic on rising edge
- `reset` in 1: synchronous, active-high
- `play` in 1: start request, sampled each edge
- `clip_sel` in 2: clip index (0 win, 1 moo, 2 detect, 3 cheer), sampled with `play`
- `loop` in 1: repeat the clip instead of finishing; sampled at end of clip
- `stop` in 1: abort playback
- `rom_address` out ADDR_W: address to sample ROM
- `rom_q` in SAMPLE_W: ROM data; valid 1 cycle after the address is clocked into the ROM
- `audio_out_allowed` in 1: Audio_Controller FIFO has space
- `write_audio_out` out 1: sample write strobe
- `left_channel_audio_out` out 32: `{sample_reg, 26'b0}`
- `right_channel_audio_out` out 32: identical to left
- `busy` out 1: high in PLAY
- `done` out 1: one-cycle pulse on natural clip end

## Operation
- States are IDLE and PLAY. Registers: `start_reg`, `end_reg`, `addr`, `div_cnt` (counts 0..SAMPLE_DIV-1), `sample_reg`, `pending`.
- Reset values: state IDLE, `rom_address` = 0, `sample_reg` = 0, `pending` = 0, `busy` = 0, `done` = 0, `write_audio_out` = 0, audio outputs 0.
- IDLE → PLAY when `play`=1 and `stop`=0:
  - latch bounds for `clip_sel`;
  - `addr` ← start, `div_cnt` ← 0.
- In PLAY, `div_cnt` increments each cycle.
- At the edge ending the cycle with `div_cnt`==1: `sample_reg` ← `rom_q`, `pending` ← 1. If `pending` is already set, the old sample is overwritten (dropped).
- At the edge ending the cycle with `div_cnt`==SAMPLE_DIV-1:
  - if `addr` < `end_reg`: `addr`+1, `div_cnt` ← 0;
  - else if `loop`: `addr` ← `start_reg`, `div_cnt` ← 0;
  - else: go to IDLE, `done` = 1 for the next cycle.
- Handshake: `write_audio_out` = `pending` & `audio_out_allowed` (combinational). `pending` clears on the edge where the strobe is high. This holds in IDLE too, so the last sample still drains.
- `stop` in PLAY: next edge goes to IDLE, clears `pending`, no `done`.
- `play` in PLAY with `stop`=0 retriggers: new bounds latched, `addr` ← new start, `div_cnt` ← 0, `pending` cleared.
- `stop` and `play` asserted together: `stop` wins; the block ends in IDLE.
- `reset` overrides everything, including mid-clip.
- `rom_address` = `addr` while in PLAY; it holds its last value in IDLE.
- Address arithmetic is unsigned ADDR_W. Bounds satisfy start ≤ end, so no wrap past 2^ADDR_W.

## Timing
- `play` sampled at edge T0 → `busy`=1 and `rom_address`=start from T0.
- Each address is held exactly SAMPLE_DIV cycles. The sample period is SAMPLE_DIV cycles (≈41.67 kHz at the default).
- ROM latency 1: the address is registered by the ROM at end of `div_cnt`=0; `q` is captured at end of `div_cnt`=1.
- A clip of N samples: `done` high during cycle [T0 + N·SAMPLE_DIV], and `busy` low from that cycle.
- `write_audio_out` may assert no earlier than cycle T0+2.

## Test plan
- Reset mid-clip: assert `reset` during PLAY → next cycle `busy`=0, `rom_address`=0, `write_audio_out`=0, `sample_reg`=0.
- Basic clip (SAMPLE_DIV=4, WIN_END=3, `audio_out_allowed`=1): pulse `play` with `clip_sel`=0 → addresses 0,1,2,3 each held 4 cycles; 4 writes carrying ROM words 0–3; `done` pulse at T0+16.
- Clip select and loop (`clip_sel`=2, `loop`=1, DETECT range shortened to 66983..66984) → address sequence 66983, 66984, 66983, …; no `done`. Drop `loop` → `done` after the next 66984 period.
- Backpressure: hold `audio_out_allowed`=0 for 6 cycles after a capture (SAMPLE_DIV=4) → first sample dropped, only the second written once allowed; exactly one strobe per allowed cycle with `pending`.
- Stop/retrigger: `stop` at `div_cnt`=2 → IDLE next cycle, no `done`, no further writes. `play` with `clip_sel`=3 mid-clip 1 → `rom_address`=83255 next cycle. `play` and `stop` together → stays or returns to IDLE.
- Drain after end: `audio_out_allowed`=0 across the final sample, then 1 → exactly one write occurs while IDLE, carrying the final ROM word.
